// File: rtl/ysyx_22050550_radix2_divider.sv
// ysyx_22050550_radix2_divider
//
// Multi-cycle radix-2 restoring integer divider for the EXU (DIV/DIVU/REM/REMU
// and the RV64 word forms). One request is accepted through a valid/ready
// handshake. Quotient and remainder come back with a one-cycle done pulse at a
// fixed latency: WIDTH+1 cycles after accept, or WIDTH/2+1 in word mode.
//
// Ports
//   clock             rising-edge clock
//   reset             synchronous active-high reset
//   io_Exu_DivValid   request valid
//   io_Exu_Flush      abort in-flight operation, suppress the done pulse, block accept
//   io_Exu_Divw       word mode: low WIDTH/2 bits of operands, sign-extended results
//   io_Exu_DivSigned  [1] dividend signed, [0] divisor signed
//   io_Exu_Divdend    dividend
//   io_Exu_Divisor    divisor
//   io_Exu_DivReady   idle, request can be accepted
//   io_Exu_OutValid   one-cycle result pulse
//   io_Exu_Quotient   quotient, held until the next completion
//   io_Exu_Remainder  remainder, held until the next completion
module ysyx_22050550_radix2_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_Exu_DivValid,
    input  logic             io_Exu_Flush,
    input  logic             io_Exu_Divw,
    input  logic [1:0]       io_Exu_DivSigned,
    input  logic [WIDTH-1:0] io_Exu_Divdend,
    input  logic [WIDTH-1:0] io_Exu_Divisor,
    output logic             io_Exu_DivReady,
    output logic             io_Exu_OutValid,
    output logic [WIDTH-1:0] io_Exu_Quotient,
    output logic [WIDTH-1:0] io_Exu_Remainder
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic             accept;
    logic             done_commit;

    logic [WIDTH-1:0] rem_reg, dvd_reg, dsr_reg, orig_dvd_reg;
    logic [CW-1:0]    cnt_reg;
    logic             q_sign_reg, r_sign_reg, word_reg, dz_reg;
    logic [WIDTH-1:0] q_fin_reg, r_fin_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;

    function automatic logic [WIDTH-1:0] sext_half(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    // Operand preparation; index 1 is the dividend and index 0 the divisor,
    // matching the bit order of io_Exu_DivSigned.
    logic [WIDTH-1:0] opnd_raw [2];
    logic [WIDTH-1:0] opnd_ext [2];
    logic [WIDTH-1:0] opnd_abs [2];
    logic [1:0]       opnd_neg;

    assign opnd_raw[1] = io_Exu_Divdend;
    assign opnd_raw[0] = io_Exu_Divisor;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            assign opnd_ext[gi] = io_Exu_Divw
                ? {{HALF{io_Exu_DivSigned[gi] & opnd_raw[gi][HALF-1]}}, opnd_raw[gi][HALF-1:0]}
                : opnd_raw[gi];
            assign opnd_neg[gi] = io_Exu_DivSigned[gi] & opnd_ext[gi][WIDTH-1];
            // Magnitude of the most-negative value wraps to itself, which is
            // the correct unsigned magnitude, so overflow needs no special case.
            assign opnd_abs[gi] = opnd_neg[gi] ? -opnd_ext[gi] : opnd_ext[gi];
        end
    endgenerate

    assign accept      = (state_reg == IDLE) && io_Exu_DivValid && !io_Exu_Flush;
    assign done_commit = (state_reg == DONE) && !io_Exu_Flush;

    // One restoring iteration. The partial remainder is below the divisor, so
    // after the shift it needs one extra bit; the trial difference then lies
    // within (-divisor, divisor) and its MSB is a reliable sign.
    logic [WIDTH:0]   trial_upper, trial_diff;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next, dvd_next;

    always_comb begin
        trial_upper = {rem_reg, dvd_reg[WIDTH-1]};
        trial_diff  = trial_upper - {1'b0, dsr_reg};
        trial_ok    = ~trial_diff[WIDTH];
        rem_next    = trial_ok ? trial_diff[WIDTH-1:0] : trial_upper[WIDTH-1:0];
        dvd_next    = {dvd_reg[WIDTH-2:0], trial_ok};
    end

    // Final sign correction, computed from the last iteration's results so the
    // corrected values are already registered when DONE is entered.
    logic [WIDTH-1:0] q_mag, q_cor, r_cor, q_fin_next, r_fin_next;

    always_comb begin
        q_mag = word_reg ? {{HALF{1'b0}}, dvd_next[HALF-1:0]} : dvd_next;
        q_cor = q_sign_reg ? -q_mag : q_mag;
        r_cor = r_sign_reg ? -rem_next : rem_next;
        if (dz_reg) begin
            q_fin_next = '1;
            r_fin_next = word_reg ? sext_half(orig_dvd_reg[HALF-1:0]) : orig_dvd_reg;
        end else begin
            q_fin_next = word_reg ? sext_half(q_cor[HALF-1:0]) : q_cor;
            r_fin_next = word_reg ? sext_half(r_cor[HALF-1:0]) : r_cor;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = BUSY;
            BUSY: begin
                if (io_Exu_Flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs. During the committing DONE cycle the fresh result is shown
    // directly from the staging registers; otherwise the held result is shown.
    always_comb begin
        io_Exu_DivReady  = (state_reg == IDLE);
        io_Exu_OutValid  = done_commit;
        io_Exu_Quotient  = done_commit ? q_fin_reg : quotient_reg;
        io_Exu_Remainder = done_commit ? r_fin_reg : remainder_reg;
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_reg       <= '0;
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            orig_dvd_reg  <= '0;
            cnt_reg       <= '0;
            q_sign_reg    <= 1'b0;
            r_sign_reg    <= 1'b0;
            word_reg      <= 1'b0;
            dz_reg        <= 1'b0;
            q_fin_reg     <= '0;
            r_fin_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            if (accept) begin
                rem_reg      <= '0;
                // Word mode runs HALF iterations, so the dividend must start
                // in the upper half to be shifted out first.
                dvd_reg      <= io_Exu_Divw ? {opnd_abs[1][HALF-1:0], {HALF{1'b0}}} : opnd_abs[1];
                dsr_reg      <= opnd_abs[0];
                orig_dvd_reg <= io_Exu_Divdend;
                cnt_reg      <= io_Exu_Divw ? CW'(HALF) : CW'(WIDTH);
                q_sign_reg   <= opnd_neg[1] ^ opnd_neg[0];
                r_sign_reg   <= opnd_neg[1];
                word_reg     <= io_Exu_Divw;
                dz_reg       <= (opnd_ext[0] == '0);
            end else if (state_reg == BUSY) begin
                rem_reg <= rem_next;
                dvd_reg <= dvd_next;
                cnt_reg <= cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    q_fin_reg <= q_fin_next;
                    r_fin_reg <= r_fin_next;
                end
            end
            if (done_commit) begin
                quotient_reg  <= q_fin_reg;
                remainder_reg <= r_fin_reg;
            end
        end
    end

endmodule

// File: doc/ysyx_22050550_radix2_divider.md
# ysyx_22050550_radix2_divider

Multi-cycle radix-2 restoring integer divider that serves the EXU's divide requests for DIV, DIVU and the RV64 word variants. It accepts one request through a valid/ready handshake and returns quotient and remainder with a one-cycle done pulse, at fixed latency. It sits beside the ALU inside the EXU. The EXU holds operands stable while the request is outstanding and latches the result on the pulse.

## Interface
Parameters:
- WIDTH, 64, operand and result width. Must be even. Word mode uses WIDTH/2.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_Exu_DivValid  in  1  request valid.
- io_Exu_Flush  in  1  abort any in-flight operation.
- io_Exu_Divw  in  1  word mode: use low WIDTH/2 bits of each operand; results are sign-extended.
- io_Exu_DivSigned  in  2  bit1: dividend signed; bit0: divisor signed. 2'b11 is signed, 2'b00 is unsigned.
- io_Exu_Divdend  in  WIDTH  dividend.
- io_Exu_Divisor  in  WIDTH  divisor.
- io_Exu_DivReady  out  1  divider idle and able to accept a request.
- io_Exu_OutValid  out  1  one-cycle pulse: result valid.
- io_Exu_Quotient  out  WIDTH  quotient, registered.
- io_Exu_Remainder  out  WIDTH  remainder, registered.

## Operation
States are IDLE, BUSY and DONE.

- **IDLE**
  - DivReady = 1.
  - Accept when DivValid && !Flush. Capture:
    - absolute values of the operands;
    - quotient sign = dividend-negative XOR divisor-negative;
    - remainder sign = dividend-negative;
    - word flag;
    - a divide-by-zero flag;
    - the original dividend, kept for the divide-by-zero case.
  - Load iteration counter N = WIDTH (or WIDTH/2 in word mode). Go to BUSY.
- **Operand preparation (word mode)**
  - Take the low WIDTH/2 bits.
  - Sign-extend when the corresponding DivSigned bit is set, otherwise zero-extend.
  - Run the division at WIDTH/2 iterations.
- **BUSY** (one iteration per cycle)
  - Shift the {remainder, dividend} register left by 1.
  - Trial-subtract the divisor from the upper half, using WIDTH+1-bit arithmetic.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. When the counter reaches 1, go to DONE.
- **DONE**
  - Correct signs: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - In word mode, sign-extend bit WIDTH/2-1 of both results.
  - Load the result registers. OutValid = 1 for this cycle only. Return to IDLE.
  - DivReady = 0 in BUSY and DONE.
- **Divide by zero** (divisor zero after word truncation)
  - Quotient = all ones; remainder = original dividend (word-truncated and sign-extended in word mode).
  - Sign correction is bypassed. Latency is unchanged.
- **Signed overflow** (most-negative / -1)
  - Quotient = most-negative value, remainder = 0.
  - This falls out of the unsigned-magnitude datapath and must not be special-cased incorrectly.
- **Flush**
  - In BUSY or DONE: next state IDLE.
  - OutValid is forced to 0 combinationally in the flush cycle.
  - Result registers are not updated.
  - Flush in IDLE blocks acceptance.
- **Back-to-back requests**
  - If DivValid is still high in the IDLE cycle after DONE, a new operation starts.
  - Each completion produces exactly one OutValid pulse.

## Timing
- Reset values: state IDLE, DivReady 1, OutValid 0, Quotient 0, Remainder 0, counter 0, all internal registers 0.
- Reset in any state aborts the operation with no OutValid pulse.
- Latency: accept in cycle 0 → BUSY in cycles 1..N → DONE, with OutValid = 1, in cycle N+1.
  - 64-bit: OutValid in cycle 65 after accept.
  - Word mode: OutValid in cycle 33 after accept.
- Outputs are registered.
  - Quotient and Remainder are valid from the DONE cycle.
  - Both hold their value until the next completion.
- Operand inputs are sampled only in the accept cycle; later changes have no effect.
- The next acceptance is possible in cycle N+2, giving a sustained throughput of one op per N+2 cycles.

## Test plan
- **Unsigned divide:** 100 / 7, DivSigned = 00, Divw = 0 → OutValid exactly in cycle 65; Quotient 14, Remainder 2; DivReady low in cycles 1..65.
- **Signed divide:** -7 / 2, DivSigned = 11 → Quotient 0xFFFFFFFFFFFFFFFD, Remainder 0xFFFFFFFFFFFFFFFF. 
- **Signed overflow:** 0x8000000000000000 / -1 → Quotient 0x8000000000000000, Remainder 0.
- **Word mode:** Divw = 1, signed. Dividend 0x1234567880000000, divisor 0xFFFFFFFFFFFFFFFF → OutValid in cycle 33; Quotient 0xFFFFFFFF80000000, Remainder 0.
- **Divide by zero:** signed -5 / 0 → Quotient 0xFFFFFFFFFFFFFFFF, Remainder 0xFFFFFFFFFFFFFFFB, latency 65. Unsigned 9 / 0 → Quotient all ones, Remainder 9.
- **Flush and reset:**
  - Flush in cycle 10 of an op → no OutValid, DivReady = 1 in cycle 11. A following 100 / 7 completes correctly.
  - Reset asserted in cycle 20 → all outputs at reset values the next cycle.
  - Flush asserted in the DONE cycle → OutValid stays 0 and Quotient is unchanged.
